// File: rtl/des.sv
// -----------------------------------------------------------------------------
// des : 16x16 Conway's Game of Life evolution engine.
//
// Holds a 256-cell board in a register. The board is loaded from a parallel
// seed input and advances one generation on every enabled clock edge. Cells
// outside the 16x16 area are treated as permanently dead; there is no
// wrap-around. The next board is computed combinationally from the current
// board, so all 256 cells update together on the same edge.
//
// Ports
//   clk_i    : sole clock, rising-edge active
//   rst_ni   : asynchronous, active-low reset; clears board and counter
//   grid_i   : seed pattern, cell (r,c) = bit r*16+c
//   load_i   : load grid_i into the board and clear the counter (wins over run)
//   run_i    : advance one generation and increment the counter
//   q_o      : current board (registered), same mapping as grid_i
//   gen_o    : generation counter (registered), wraps 0xFFFF -> 0x0000
// -----------------------------------------------------------------------------
module des (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [255:0] grid_i,
  input  logic         load_i,
  input  logic         run_i,
  output logic [255:0] q_o,
  output logic [15:0]  gen_o
);

  logic [255:0] board_q, board_d;
  logic [15:0]  gen_q, gen_d;
  logic [255:0] board_next;

  // Apply the survival/birth rule to every cell. Neighbour positions that fall
  // outside 0..15 in either axis are simply skipped, which makes the border
  // behave as a ring of dead cells.
  function automatic logic [255:0] life_next(input logic [255:0] b);
    logic [255:0] nb;
    logic [3:0]   cnt;
    int           rr;
    int           cc;
    nb = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        cnt = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16) begin
              cnt = cnt + {3'b000, b[rr*16 + cc]};
            end
          end
        end
        nb[r*16 + c] = (cnt == 4'd3) || (b[r*16 + c] && (cnt == 4'd2));
      end
    end
    return nb;
  endfunction

  assign board_next = life_next(board_q);

  // Load has priority; run evolves; otherwise hold.
  always_comb begin
    board_d = board_q;
    gen_d   = gen_q;
    if (load_i) begin
      board_d = grid_i;
      gen_d   = 16'h0000;
    end else if (run_i) begin
      board_d = board_next;
      gen_d   = gen_q + 16'h0001;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      board_q <= '0;
      gen_q   <= 16'h0000;
    end else begin
      board_q <= board_d;
      gen_q   <= gen_d;
    end
  end

  assign q_o   = board_q;
  assign gen_o = gen_q;

endmodule

// File: tb/tb_des.sv
module tb_des;

  logic         clk;
  logic         rst_n;
  logic [255:0] grid;
  logic         load;
  logic         run;
  logic [255:0] q;
  logic [15:0]  gen;

  int tests;
  int fails;

  des dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .grid_i (grid),
    .load_i (load),
    .run_i  (run),
    .q_o    (q),
    .gen_o  (gen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [255:0] seed;
    int           steps;
    logic [255:0] exp_q;
    logic [15:0]  exp_gen;
  } vec_t;

  vec_t vecs[7];

  // Build a board from up to four cell indices; negative entries are unused.
  function automatic logic [255:0] cells(input int a, input int b, input int c, input int d);
    logic [255:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  // Reference model: pad the board with a dead border into an 18x18 array,
  // then take the 3x3 window sum minus the centre as the neighbour count.
  function automatic logic [255:0] ref_next(input logic [255:0] b);
    bit           p [0:17][0:17];
    logic [255:0] nb;
    int           n;
    for (int i = 0; i < 18; i++)
      for (int j = 0; j < 18; j++)
        p[i][j] = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        p[r+1][c+1] = b[r*16 + c];
    nb = '0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        n = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            n += int'(p[r+i][c+j]);
        n -= int'(p[r+1][c+1]);
        nb[r*16 + c] = (n == 3) || (p[r+1][c+1] && n == 2);
      end
    end
    return nb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_load(input logic [255:0] g);
    grid = g;
    load = 1'b1;
    run  = 1'b0;
    tick();
    load = 1'b0;
    grid = '0;
  endtask

  logic [255:0] m_q;
  logic [15:0]  m_gen;
  logic [255:0] rg;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    grid  = '0;
    load  = 1'b0;
    run   = 1'b0;

    vecs[0] = '{"blinker_1",   cells(84, 85, 86, -1),  1, cells(69, 85, 101, -1),  16'd1};
    vecs[1] = '{"blinker_2",   cells(84, 85, 86, -1),  2, cells(84, 85, 86, -1),   16'd2};
    vecs[2] = '{"corner_1",    cells(0, 1, 16, -1),    1, cells(0, 1, 16, 17),     16'd1};
    vecs[3] = '{"corner_4",    cells(0, 1, 16, -1),    4, cells(0, 1, 16, 17),     16'd4};
    vecs[4] = '{"edge_nowrap", cells(15, 31, 47, -1),  1, cells(30, 31, -1, -1),   16'd1};
    vecs[5] = '{"single_dies", cells(120, -1, -1, -1), 1, '0,                      16'd1};
    vecs[6] = '{"empty_3",     '0,                     3, '0,                      16'd3};

    // Reset at time zero.
    #2;
    chk("reset_q", q, '0);
    chk("reset_gen", {240'd0, gen}, 256'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven known patterns.
    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].seed);
      chk({vecs[i].name, "_load_q"}, q, vecs[i].seed);
      chk({vecs[i].name, "_load_gen"}, {240'd0, gen}, 256'd0);
      run = 1'b1;
      for (int s = 0; s < vecs[i].steps; s++) tick();
      run = 1'b0;
      chk({vecs[i].name, "_q"}, q, vecs[i].exp_q);
      chk({vecs[i].name, "_gen"}, {240'd0, gen}, {240'd0, vecs[i].exp_gen});
    end

    // Asynchronous reset mid-cycle with a non-empty board.
    do_load(cells(84, 85, 86, -1));
    run = 1'b1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", q, '0);
    chk("async_rst_gen", {240'd0, gen}, 256'd0);
    grid = cells(1, 2, 3, -1);
    load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_hold_q", q, '0);
      chk("rst_hold_gen", {240'd0, gen}, 256'd0);
    end
    load = 1'b0;
    rst_n = 1'b1;
    // Run on the cleared board: stays empty while counting.
    for (int k = 0; k < 3; k++) tick();
    run = 1'b0;
    chk("post_rst_q", q, '0);
    chk("post_rst_gen", {240'd0, gen}, 256'd3);

    // Load and run together: load wins; then hold for 5 cycles.
    grid = 256'h1;
    load = 1'b1;
    run  = 1'b1;
    tick();
    load = 1'b0;
    run  = 1'b0;
    grid = '1;
    chk("prio_q", q, 256'h1);
    chk("prio_gen", {240'd0, gen}, 256'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("hold_q", q, 256'h1);
      chk("hold_gen", {240'd0, gen}, 256'd0);
    end

    // Randomized stimulus against the reference model.
    rg = '0;
    for (int w = 0; w < 8; w++) rg[w*32 +: 32] = $urandom() & $urandom();
    do_load(rg);
    m_q   = rg;
    m_gen = 16'd0;
    for (int k = 0; k < 300; k++) begin
      for (int w = 0; w < 8; w++) grid[w*32 +: 32] = $urandom() & $urandom();
      load = ($urandom_range(0, 19) == 0);
      run  = ($urandom_range(0, 3) != 0);
      if (load) begin
        m_q   = grid;
        m_gen = 16'd0;
      end else if (run) begin
        m_q   = ref_next(m_q);
        m_gen = m_gen + 16'd1;
      end
      tick();
      chk("rand_q", q, m_q);
      chk("rand_gen", {240'd0, gen}, {240'd0, m_gen});
    end
    load = 1'b0;
    run  = 1'b0;

    // Counter wrap on an empty board.
    do_load('0);
    run = 1'b1;
    for (int k = 0; k < 65535; k++) tick();
    chk("wrap_gen_ffff", {240'd0, gen}, {240'd0, 16'hFFFF});
    tick();
    run = 1'b0;
    chk("wrap_gen_0", {240'd0, gen}, 256'd0);
    chk("wrap_q", q, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
